// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP multiplier family: default mantissa/product
// widths and the sequential multiplier state type.
package fp_mul_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int PROD_W_DEF = 2 * MANT_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mant_mult_seq_if.sv
// Handshake bundle around mant_mult_seq: operand request channel, result
// channel, flush and busy. The master is the operand producer / result consumer.
interface mant_mult_seq_if #(
  parameter int MANT_W = 24,
  parameter int PROD_W = 2 * MANT_W
);

  // Both channels are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both 1; valid holds its payload until that edge.
  logic              start_valid;
  logic              start_ready;
  logic [MANT_W-1:0] multiplicand;
  logic [MANT_W-1:0] multiplier;
  logic              flush;
  logic              result_valid;
  logic              result_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (
    output start_valid, multiplicand, multiplier, flush, result_ready,
    input  start_ready, result_valid, product, busy
  );

  modport slave (
    input  start_valid, multiplicand, multiplier, flush, result_ready,
    output start_ready, result_valid, product, busy
  );

endinterface

// File: rtl/mant_mult_seq.sv
// Sequential shift-and-add mantissa multiplier, one multiplier bit per cycle.
// Optional macro MANT_MULT_EARLY_TERM_EN ends the run once no multiplier bits remain.
module mant_mult_seq
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int PROD_W = 2 * MANT_W
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_start_valid,
  output logic              out_start_ready,
  input  logic [MANT_W-1:0] in_multiplicand,
  input  logic [MANT_W-1:0] in_multiplier,
  input  logic              in_flush,
  output logic              out_result_valid,
  input  logic              in_result_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_busy,
  output state_e            out_dbg_state
);

  localparam int CNT_W = $clog2(MANT_W + 1);

  state_e            state_q, state_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_start_valid) begin
          mcand_d  = {{(PROD_W-MANT_W){1'b0}}, in_multiplicand};
          mplier_d = in_multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MANT_W - 1)) begin
          state_d = DONE;
        end
`ifdef MANT_MULT_EARLY_TERM_EN
        // Remaining multiplier bits are all zero: the accumulator is final.
        if (mplier_d == '0) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (in_result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush outranks both handshakes; leftover datapath contents are dead.
    if (in_flush) begin
      state_d = IDLE;
    end

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign out_start_ready  = ready_q;
  assign out_result_valid = valid_q;
  assign out_busy         = busy_q;
  assign out_product      = acc_q;
  assign out_dbg_state    = state_q;

endmodule

// File: doc/mant_mult_seq.md
MANT_MULT_SEQ -- requirements
Module: mant_mult_seq

Interface
REQ-001 SHALL have parameter MANT_W, default 24, mantissa width including hidden bit.
REQ-002 SHALL have parameter PROD_W, default 2*MANT_W, product width.
REQ-003 SHALL have port in_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port in_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_start_valid  input  1  operands present.
REQ-006 SHALL have port out_start_ready  output  1  block can accept operands.
REQ-007 SHALL have port in_multiplicand  input  MANT_W  unsigned mantissa A.
REQ-008 SHALL have port in_multiplier  input  MANT_W  unsigned mantissa B.
REQ-009 SHALL have port in_flush  input  1  synchronous abort.
REQ-010 SHALL have port out_result_valid  output  1  product available.
REQ-011 SHALL have port in_result_ready  input  1  consumer takes product.
REQ-012 SHALL have port out_product  output  PROD_W  A*B, unsigned.
REQ-013 SHALL have port out_busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL use FSM states IDLE, RUN, DONE. out_start_ready is 1 only in IDLE; out_result_valid is 1 only in DONE.
REQ-015 SHALL, on an edge with IDLE and in_start_valid=1, latch both operands, clear the accumulator and bit counter, and enter RUN. Operand changes after that edge are ignored.
REQ-016 SHALL, per RUN cycle, add the shifted multiplicand into a PROD_W accumulator when the current multiplier LSB is 1, then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter. No overflow is possible at PROD_W.
REQ-017 SHALL leave RUN for DONE on the edge that processes multiplier bit MANT_W-1. out_result_valid therefore rises exactly MANT_W edges after the accept edge (24 at default).
REQ-018 SHALL, in DONE, hold out_product stable and equal to A*B until the edge with in_result_ready=1, then return to IDLE. It SHALL NOT accept new operands on that same edge.
REQ-019 SHALL drive out_product from the accumulator register; its value is undefined for consumers outside DONE.
REQ-020 SHALL, when in_flush=1 on an edge, go to IDLE from any state and discard in-flight work. in_flush has priority over start and result handshakes on that edge.
REQ-021 SHALL treat in_result_ready as don't-care outside DONE and in_start_valid as don't-care outside IDLE.

Reset
REQ-022 SHALL, while in_rst_n=0, asynchronously force: state IDLE, out_start_ready=1, out_result_valid=0, out_busy=0, out_product=0, counter=0, operand registers=0.
REQ-023 SHALL, on reset during RUN or DONE, drop the in-flight product without any out_result_valid pulse.

Configuration
REQ-024 SHALL support macro MANT_MULT_EARLY_TERM_EN.
REQ-025 With MANT_MULT_EARLY_TERM_EN defined, SHALL also leave RUN for DONE on the edge where the post-shift multiplier register equals 0. Latency becomes max(1, index of highest set bit of B + 1) edges.
REQ-026 Without MANT_MULT_EARLY_TERM_EN, SHALL have a fixed latency of MANT_W edges for all operands.

Structure
REQ-027 SHALL take MANT_W/PROD_W defaults and the state typedef (IDLE, RUN, DONE) from shared package fp_mul_pkg, reused by the FP multiplier top.
REQ-028 SHALL be a single module with no sub-module; add-and-shift datapath and FSM stay in one file.

Verification
REQ-029 SHALL cover: A=0x800000, B=0x800000 -> product 0x400000000000, valid 24 edges after accept (fixed mode).
REQ-030 SHALL cover: A=0xFFFFFF, B=0xFFFFFF -> 0xFFFFFE000001; hold in_result_ready=0 for 5 cycles -> product and valid stable, out_start_ready=0.
REQ-031 SHALL cover: A=0xC00000, B=0xC00000 -> 0x900000000000. Also B=0x000001 with MANT_MULT_EARLY_TERM_EN -> valid after 1 edge; without it -> 24 edges.
REQ-032 SHALL cover: in_flush asserted at RUN cycle 10 -> IDLE next edge, no valid pulse; the next op A=0x123456, B=0x000002 -> 0x00000002468AC.
REQ-033 SHALL cover: in_rst_n low during DONE -> all outputs reach reset values immediately without a clock edge; start and flush asserted on the same edge -> flush wins, block stays IDLE.
REQ-034 SHALL cover: 1000 random back-to-back transactions with random ready stalls, checked against a reference A*B model.
